if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage, directly upstream of the IF/ID pipeline register.
- Owns the PC and drives a variable-latency instruction-memory request/acknowledge interface.
- Presents {instruction, PC, PC+4, valid} to IF/ID through a registered output buffer with a one-entry skid register, so a stall never loses or duplicates an instruction.
- Accepts branch/jump redirects from the decode stage and squashes wrong-path fetches, including a fetch already in flight at the memory.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  downstream hold; IF/ID does not load this cycle (IF/ID enable = !stall).
- redirect_valid  input  1  taken branch/jump this cycle.
- redirect_pc  input  32  redirect target, word-aligned.
- imem_req  output  1  fetch request, level signal.
- imem_addr  output  32  fetch address; stable while imem_req is high.
- imem_ack  input  1  one-cycle pulse; imem_rdata is valid in that cycle.
- imem_rdata  input  32  fetched instruction.
- Instruction_Out  output  32  instruction to IF/ID.
- PC_Out  output  32  address of Instruction_Out.
- PC_4_Out  output  32  PC_Out+4.
- Valid_Out  output  1  output buffer holds a live instruction.

Behaviour:
- Reset (synchronous, priority over all inputs):
  - pc=RESET_PC, state=REQ.
  - Valid_Out=0; Instruction_Out, PC_Out and PC_4_Out = 0.
  - Skid register and pending target cleared.
  - imem_req=0 during the reset cycle.
  - The instruction memory shares this reset and aborts any outstanding request.
- Consume rule: the output buffer is consumed in any cycle with Valid_Out=1 and stall=0. The buffer is free when Valid_Out=0 or it is being consumed.
- imem_req = (state==REQ or state==DROP) and !reset.
  - imem_addr = pc.
  - Once raised, req and addr are held until ack.
  - Ack may arrive in the first req cycle (zero wait).
- States: REQ, HOLD, DROP.
- REQ:
  - ack, no redirect, buffer free: output <= {rdata, pc, pc+4}, Valid_Out=1, pc<=pc+4, stay REQ. Back-to-back single-cycle fetches must sustain 1 instruction per clock.
  - ack, no redirect, buffer not free: skid <= {rdata, pc}, pc<=pc+4, go HOLD.
  - No ack: output buffer is unchanged except for consumption (consumed -> Valid_Out=0).
- HOLD:
  - imem_req=0.
  - When the buffer is free: output <= skid, Valid_Out=1, go REQ. The next request is raised in the following cycle.
- Redirect (redirect_valid=1) has priority over stall and ack in every state:
  - Next cycle Valid_Out=0 (flush of the wrong-path instruction).
  - REQ with ack same cycle: rdata discarded; pc<=redirect_pc; stay REQ.
  - REQ without ack: pending_pc<=redirect_pc; go DROP.
  - HOLD: skid discarded; pc<=redirect_pc; go REQ.
  - DROP: pending_pc overwritten with the newest redirect_pc. If ack arrives the same cycle, pc<=redirect_pc and go REQ.
- DROP:
  - Keeps req high at the old address.
  - On ack: rdata discarded, pc<=pending_pc, go REQ.
  - Valid_Out stays 0 throughout DROP.
- Arithmetic: pc+4 is a 32-bit add, modulo 2^32 (0xFFFF_FFFC+4 = 0x0000_0000). PC_4_Out = PC_Out+4 with the same wrap.
- Output hold: while stall=1 and no redirect, all outputs hold their values.
- No instruction is ever presented twice or dropped except by redirect.

Test Plan:
- Reset, zero-wait memory (ack in same cycle as req), stall=0, rdata=addr^0xA5A5A5A5 -> Valid_Out=1 from the 2nd cycle after reset release; PC_Out sequence 0x0,0x4,0x8,... one per clock; PC_4_Out=PC_Out+4.
- Zero-wait memory, stall=1 for 3 cycles starting with buffer full at PC 0x8 -> ack for 0xC goes to skid, imem_req=0 during HOLD; after stall drops, PC_Out 0x8 then 0xC on consecutive cycles, next imem_addr=0x10.
- 3-cycle memory latency, redirect_valid with redirect_pc=0x100 one cycle after req at 0x14 -> imem_addr held at 0x14 until ack; that data is never presented; next imem_addr=0x100; first valid PC_Out=0x100.
- Redirect (0x200) in the same cycle as ack and stall=1 -> Valid_Out=0 the next cycle, rdata discarded, next imem_addr=0x200.
- RESET_PC=0xFFFF_FFF8, zero-wait memory -> PC_Out 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; PC_4_Out for 0xFFFF_FFFC is 0x0000_0000.
- reset asserted for 1 cycle while in HOLD with Valid_Out=1 -> next cycle all outputs 0, imem_req=0; the following cycle imem_req=1, imem_addr=RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, issues variable-latency imem requests and feeds IF/ID via a
// registered output buffer plus one skid entry; redirects squash wrong-path fetches, including in-flight ones.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction_Out,
  output logic [31:0] PC_Out,
  output logic [31:0] PC_4_Out,
  output logic        Valid_Out
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_pend_pc, w_pend_pc_nxt;
  logic [31:0] r_skid_instr, w_skid_instr_nxt;
  logic [31:0] r_skid_pc, w_skid_pc_nxt;
  logic [31:0] r_out_instr, w_out_instr_nxt;
  logic [31:0] r_out_pc, w_out_pc_nxt;
  logic [31:0] r_out_pc4, w_out_pc4_nxt;
  logic        r_out_vld, w_out_vld_nxt;
  logic        w_buf_free;
  logic [31:0] w_pc_plus4;

  assign w_buf_free = !r_out_vld || !stall;
  assign w_pc_plus4 = r_pc + 32'd4;
  assign imem_req   = ((r_state == S_REQ) || (r_state == S_DROP)) && !reset;
  assign imem_addr  = r_pc;

  assign Instruction_Out = r_out_instr;
  assign PC_Out          = r_out_pc;
  assign PC_4_Out        = r_out_pc4;
  assign Valid_Out       = r_out_vld;

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_pend_pc_nxt    = r_pend_pc;
    w_skid_instr_nxt = r_skid_instr;
    w_skid_pc_nxt    = r_skid_pc;
    w_out_instr_nxt  = r_out_instr;
    w_out_pc_nxt     = r_out_pc;
    w_out_pc4_nxt    = r_out_pc4;
    // A consumed buffer empties unless something below refills it.
    w_out_vld_nxt    = r_out_vld && stall;

    if (redirect_valid) begin
      w_out_vld_nxt = 1'b0;
      case (r_state)
        S_REQ: begin
          if (imem_ack) begin
            w_pc_nxt = redirect_pc;
          end else begin
            w_pend_pc_nxt = redirect_pc;
            w_state_nxt   = S_DROP;
          end
        end
        S_HOLD: begin
          w_pc_nxt    = redirect_pc;
          w_state_nxt = S_REQ;
        end
        S_DROP: begin
          w_pend_pc_nxt = redirect_pc;
          if (imem_ack) begin
            w_pc_nxt    = redirect_pc;
            w_state_nxt = S_REQ;
          end
        end
        default: w_state_nxt = S_REQ;
      endcase
    end else begin
      case (r_state)
        S_REQ: begin
          if (imem_ack) begin
            w_pc_nxt = w_pc_plus4;
            if (w_buf_free) begin
              w_out_instr_nxt = imem_rdata;
              w_out_pc_nxt    = r_pc;
              w_out_pc4_nxt   = w_pc_plus4;
              w_out_vld_nxt   = 1'b1;
            end else begin
              w_skid_instr_nxt = imem_rdata;
              w_skid_pc_nxt    = r_pc;
              w_state_nxt      = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (w_buf_free) begin
            w_out_instr_nxt = r_skid_instr;
            w_out_pc_nxt    = r_skid_pc;
            w_out_pc4_nxt   = r_skid_pc + 32'd4;
            w_out_vld_nxt   = 1'b1;
            w_state_nxt     = S_REQ;
          end
        end
        S_DROP: begin
          // The in-flight wrong-path data is thrown away; restart at the redirect target.
          if (imem_ack) begin
            w_pc_nxt    = r_pend_pc;
            w_state_nxt = S_REQ;
          end
        end
        default: w_state_nxt = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_pend_pc    <= 32'd0;
      r_skid_instr <= 32'd0;
      r_skid_pc    <= 32'd0;
      r_out_instr  <= 32'd0;
      r_out_pc     <= 32'd0;
      r_out_pc4    <= 32'd0;
      r_out_vld    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_pend_pc    <= w_pend_pc_nxt;
      r_skid_instr <= w_skid_instr_nxt;
      r_skid_pc    <= w_skid_pc_nxt;
      r_out_instr  <= w_out_instr_nxt;
      r_out_pc     <= w_out_pc_nxt;
      r_out_pc4    <= w_out_pc4_nxt;
      r_out_vld    <= w_out_vld_nxt;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_if_fetch_unit;

  localparam logic [31:0] K = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] Instruction_Out, PC_Out, PC_4_Out;
  logic        Valid_Out;

  logic        w2_req, w2_vld;
  logic [31:0] w2_addr, w2_instr, w2_pc, w2_pc4;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .Instruction_Out(Instruction_Out), .PC_Out(PC_Out),
    .PC_4_Out(PC_4_Out), .Valid_Out(Valid_Out)
  );

  // Zero-wait memory, never stalled: exercises the PC wrap-around.
  if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .reset(reset), .stall(1'b0),
    .redirect_valid(1'b0), .redirect_pc(32'd0),
    .imem_req(w2_req), .imem_addr(w2_addr),
    .imem_ack(w2_req), .imem_rdata(w2_addr ^ K),
    .Instruction_Out(w2_instr), .PC_Out(w2_pc),
    .PC_4_Out(w2_pc4), .Valid_Out(w2_vld)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Memory model state
  int mem_lat_fixed = 0;
  int cur_lat = 0;
  int mem_cnt = 0;

  // Reference model: output slot, pending fetched entries, fetch pointer, drop flag
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;
  ent_t        q[$];
  logic        m_vld = 1'b0;
  logic [31:0] m_instr = 32'd0, m_pc = 32'd0, m_pc4 = 32'd0;
  logic [31:0] m_fetch = 32'd0, m_pend = 32'd0;
  logic        m_drop = 1'b0;

  // Sampled DUT request and model expectation for the last driven cycle
  logic        s_req, e_req;
  logic [31:0] s_addr, e_addr;

  task automatic model_load(input ent_t e);
    m_instr = e.instr;
    m_pc    = e.pc;
    m_pc4   = e.pc + 32'd4;
    m_vld   = 1'b1;
  endtask

  task automatic model_step(input logic rst, input logic st, input logic rv,
                            input logic [31:0] rpc, input logic ack, input logic [31:0] rdata);
    ent_t e;
    logic free;
    if (rst) begin
      q.delete();
      m_vld = 1'b0; m_instr = 32'd0; m_pc = 32'd0; m_pc4 = 32'd0;
      m_fetch = 32'h0000_0000; m_pend = 32'd0; m_drop = 1'b0;
    end else if (rv) begin
      m_vld = 1'b0;
      if (q.size() > 0) begin
        q.delete();
        m_fetch = rpc;
      end else if (ack) begin
        m_fetch = rpc;
        m_drop  = 1'b0;
      end else begin
        m_drop = 1'b1;
        m_pend = rpc;
      end
    end else begin
      free = !m_vld || !st;
      if (m_vld && !st) m_vld = 1'b0;
      if (q.size() > 0) begin
        if (free) begin
          e = q.pop_front();
          model_load(e);
        end
      end else if (ack) begin
        if (m_drop) begin
          m_fetch = m_pend;
          m_drop  = 1'b0;
        end else begin
          e.instr = rdata;
          e.pc    = m_fetch;
          m_fetch = m_fetch + 32'd4;
          if (free) model_load(e);
          else q.push_back(e);
        end
      end
    end
  endtask

  // Drives one clock cycle (inputs at negedge, memory response #1 later), advances the model at posedge.
  task automatic drive_cycle(input logic rst, input logic st, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    reset = rst; stall = st; redirect_valid = rv; redirect_pc = rpc;
    if (mem_cnt == 0) cur_lat = (mem_lat_fixed < 0) ? int'($urandom_range(0, 3)) : mem_lat_fixed;
    #1;
    s_req  = imem_req;
    s_addr = imem_addr;
    e_req  = !rst && (q.size() == 0);
    e_addr = m_fetch;
    if (imem_req && mem_cnt >= cur_lat) begin
      imem_ack   = 1'b1;
      imem_rdata = imem_addr ^ K;
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
    end
    @(posedge clk);
    model_step(rst, st, rv, rpc, imem_ack, imem_rdata);
    if (rst || !s_req || imem_ack) mem_cnt = 0;
    else mem_cnt = mem_cnt + 1;
    #1;
  endtask

  task automatic test_reset();
    mem_lat_fixed = 0;
    drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);
    drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);
    n_checks++; if (s_req !== 1'b0) begin n_errors++; $display("FAIL reset_req: got %b want 0", s_req); end
    n_checks++; if (Valid_Out !== 1'b0) begin n_errors++; $display("FAIL reset_vld: got %b want 0", Valid_Out); end
    n_checks++; if (Instruction_Out !== 32'd0) begin n_errors++; $display("FAIL reset_instr: got %h want 0", Instruction_Out); end
    n_checks++; if (PC_Out !== 32'd0) begin n_errors++; $display("FAIL reset_pc: got %h want 0", PC_Out); end
    n_checks++; if (PC_4_Out !== 32'd0) begin n_errors++; $display("FAIL reset_pc4: got %h want 0", PC_4_Out); end
  endtask

  task automatic test_zero_wait_stream();
    logic [31:0] a;
    mem_lat_fixed = 0;
    drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b0, 32'd0);
      a = 32'(i * 4);
      n_checks++; if (s_req !== 1'b1 || s_addr !== a) begin n_errors++; $display("FAIL stream_req[%0d]: got %b/%h want 1/%h", i, s_req, s_addr, a); end
      n_checks++; if (Valid_Out !== 1'b1 || PC_Out !== a) begin n_errors++; $display("FAIL stream_pc[%0d]: got %b/%h want 1/%h", i, Valid_Out, PC_Out, a); end
      n_checks++; if (PC_4_Out !== a + 32'd4 || Instruction_Out !== (a ^ K)) begin n_errors++; $display("FAIL stream_dat[%0d]: got %h/%h want %h/%h", i, PC_4_Out, Instruction_Out, a + 32'd4, a ^ K); end
    end
  endtask

  task automatic test_stall_skid();
    mem_lat_fixed = 0;
    drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 1'b0, 32'd0);
    n_checks++; if (PC_Out !== 32'h8 || Valid_Out !== 1'b1) begin n_errors++; $display("FAIL skid_pre: got %b/%h want 1/8", Valid_Out, PC_Out); end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b0, 32'd0);
      n_checks++; if (s_req !== (i == 0) || (i == 0 && s_addr !== 32'hC)) begin n_errors++; $display("FAIL skid_req[%0d]: got %b/%h want %b/c", i, s_req, s_addr, i == 0); end
      n_checks++; if (Valid_Out !== 1'b1 || PC_Out !== 32'h8) begin n_errors++; $display("FAIL skid_hold[%0d]: got %b/%h want 1/8", i, Valid_Out, PC_Out); end
    end
    drive_cycle(1'b0, 1'b0, 1'b0, 32'd0);
    n_checks++; if (s_req !== 1'b0) begin n_errors++; $display("FAIL skid_release_req: got %b want 0", s_req); end
    n_checks++; if (Valid_Out !== 1'b1 || PC_Out !== 32'hC || Instruction_Out !== (32'hC ^ K)) begin n_errors++; $display("FAIL skid_out: got %b/%h/%h want 1/c/%h", Valid_Out, PC_Out, Instruction_Out, 32'hC ^ K); end
    drive_cycle(1'b0, 1'b0, 1'b0, 32'd0);
    n_checks++; if (s_req !== 1'b1 || s_addr !== 32'h10) begin n_errors++; $display("FAIL skid_next_addr: got %b/%h want 1/10", s_req, s_addr); end
    n_checks++; if (Valid_Out !== 1'b1 || PC_Out !== 32'h10) begin n_errors++; $display("FAIL skid_next_out: got %b/%h want 1/10", Valid_Out, PC_Out); end
  endtask

  task automatic test_redirect_inflight();
    bit seen;
    mem_lat_fixed = 0;
    drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b0, 1'b0, 32'd0);
    mem_lat_fixed = 3;
    drive_cycle(1'b0, 1'b0, 1'b0, 32'd0);
    n_checks++; if (s_req !== 1'b1 || s_addr !== 32'h14) begin n_errors++; $display("FAIL infl_first: got %b/%h want 1/14", s_req, s_addr); end
    drive_cycle(1'b0, 1'b0, 1'b1, 32'h100);
    n_checks++; if (s_addr !== 32'h14 || Valid_Out !== 1'b0) begin n_errors++; $display("FAIL infl_redir: got %h/%b want 14/0", s_addr, Valid_Out); end
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b0, 32'd0);
      n_checks++; if (s_req !== 1'b1 || s_addr !== 32'h14 || Valid_Out !== 1'b0) begin n_errors++; $display("FAIL infl_drop[%0d]: got %b/%h/%b want 1/14/0", i, s_req, s_addr, Valid_Out); end
    end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b0, 32'd0);
      if (i == 0) begin
        n_checks++; if (s_req !== 1'b1 || s_addr !== 32'h100) begin n_errors++; $display("FAIL infl_newaddr: got %b/%h want 1/100", s_req, s_addr); end
      end
      if (Valid_Out === 1'b1) begin
        seen = 1'b1;
        n_checks++; if (PC_Out !== 32'h100 || Instruction_Out !== (32'h100 ^ K)) begin n_errors++; $display("FAIL infl_firstvalid: got %h/%h want 100/%h", PC_Out, Instruction_Out, 32'h100 ^ K); end
      end
    end
    if (!seen) begin
      n_checks++; n_errors++; $display("FAIL infl_timeout: got no valid output within 10 cycles, want PC 100");
    end
  endtask

  task automatic test_redirect_ack_stall();
    mem_lat_fixed = 0;
    drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);
    drive_cycle(1'b0, 1'b0, 1'b0, 32'd0);
    drive_cycle(1'b0, 1'b0, 1'b0, 32'd0);
    drive_cycle(1'b0, 1'b1, 1'b1, 32'h200);
    n_checks++; if (s_req !== 1'b1 || s_addr !== 32'h8) begin n_errors++; $display("FAIL rs_req: got %b/%h want 1/8", s_req, s_addr); end
    n_checks++; if (Valid_Out !== 1'b0) begin n_errors++; $display("FAIL rs_flush: got %b want 0", Valid_Out); end
    drive_cycle(1'b0, 1'b0, 1'b0, 32'd0);
    n_checks++; if (s_req !== 1'b1 || s_addr !== 32'h200) begin n_errors++; $display("FAIL rs_addr: got %b/%h want 1/200", s_req, s_addr); end
    n_checks++; if (Valid_Out !== 1'b1 || PC_Out !== 32'h200) begin n_errors++; $display("FAIL rs_out: got %b/%h want 1/200", Valid_Out, PC_Out); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    logic [31:0] exp_pc4 [3];
    exp_pc  = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    exp_pc4 = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    mem_lat_fixed = 0;
    drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b0, 32'd0);
      n_checks++; if (w2_vld !== 1'b1 || w2_pc !== exp_pc[i] || w2_pc4 !== exp_pc4[i]) begin n_errors++; $display("FAIL wrap[%0d]: got %b/%h/%h want 1/%h/%h", i, w2_vld, w2_pc, w2_pc4, exp_pc[i], exp_pc4[i]); end
    end
  endtask

  task automatic test_reset_in_hold();
    mem_lat_fixed = 0;
    drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);
    drive_cycle(1'b0, 1'b0, 1'b0, 32'd0);
    drive_cycle(1'b0, 1'b1, 1'b0, 32'd0);
    n_checks++; if (Valid_Out !== 1'b1 || PC_Out !== 32'd0) begin n_errors++; $display("FAIL rh_pre: got %b/%h want 1/0", Valid_Out, PC_Out); end
    drive_cycle(1'b1, 1'b1, 1'b0, 32'd0);
    n_checks++; if (s_req !== 1'b0) begin n_errors++; $display("FAIL rh_req: got %b want 0", s_req); end
    n_checks++; if (Valid_Out !== 1'b0 || Instruction_Out !== 32'd0 || PC_Out !== 32'd0 || PC_4_Out !== 32'd0) begin n_errors++; $display("FAIL rh_out: got %b/%h/%h/%h want all 0", Valid_Out, Instruction_Out, PC_Out, PC_4_Out); end
    drive_cycle(1'b0, 1'b0, 1'b0, 32'd0);
    n_checks++; if (s_req !== 1'b1 || s_addr !== 32'd0) begin n_errors++; $display("FAIL rh_restart: got %b/%h want 1/0", s_req, s_addr); end
  endtask

  task automatic test_random();
    logic rst, st, rv;
    logic [31:0] rpc;
    mem_lat_fixed = -1;
    drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      st  = ($urandom_range(0, 9) < 3);
      rv  = ($urandom_range(0, 99) < 8);
      rpc = $urandom & 32'hFFFF_FFFC;
      drive_cycle(rst, st, rv, rpc);
      n_checks++; if (s_req !== e_req || (e_req && s_addr !== e_addr)) begin n_errors++; $display("FAIL rnd_req[%0d]: got %b/%h want %b/%h", i, s_req, s_addr, e_req, e_addr); end
      n_checks++; if (Valid_Out !== m_vld) begin n_errors++; $display("FAIL rnd_vld[%0d]: got %b want %b", i, Valid_Out, m_vld); end
      n_checks++; if (PC_Out !== m_pc || PC_4_Out !== m_pc4 || Instruction_Out !== m_instr) begin n_errors++; $display("FAIL rnd_out[%0d]: got %h/%h/%h want %h/%h/%h", i, PC_Out, PC_4_Out, Instruction_Out, m_pc, m_pc4, m_instr); end
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait_stream();
    test_stall_skid();
    test_redirect_inflight();
    test_redirect_ack_stall();
    test_wrap();
    test_reset_in_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
